control_unit: RTL and testbench

Hardwired sequencer that drives the microcontroller's shared-bus datapath: ALU operand/result registers, PC, four general registers r0–r3, MAR/MDR and memory. It fetches 16-bit instructions through the memory handshake (memEN/memRW → MFC), latches them into an internal IR, decodes them, and issues one bus transfer per cycle until the instruction completes. It is the initiator for every datapath control input; the datapath is a pure responder.

---
 rtl/control_unit_pkg.sv | 53 +++++
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit_reg_sel_decode.sv | 8 +
 rtl/control_unit.sv | 157 +++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: state encodings, opcodes, IR field
// positions, memory direction values and the registered control-word layout.
package control_unit_pkg;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2, S_A3,
    S_M0,
    S_L0, S_L1, S_L2, S_L3,
    S_S0, S_S1, S_S2,
    S_HLT, S_FLT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_MOV   = 4'b0011;
  localparam logic [3:0] OP_HALT  = 4'b0100;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int IR_OP_HI = 15;
  localparam int IR_OP_LO = 12;
  localparam int IR_RD_HI = 11;
  localparam int IR_RD_LO = 10;
  localparam int IR_RS_HI = 9;
  localparam int IR_RS_LO = 8;

  // Register-file strobes are kept outside this struct; they come from reg_sel_decode.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_in0;
    logic       alu_in1;
    logic       alu_latch;
    logic       alu_out_en;
    logic       pc_out_en;
    logic       pc_inc;
    logic       mem_en;
    logic       mem_rw;
    logic       mar_in;
    logic       mdr_wr;
    logic       mdr_rd;
    logic       mdr_out;
    logic       halted;
    logic       fault;
  } ctrl_t;

  function automatic logic is_wait(state_t s);
    return (s == S_F1) || (s == S_L1) || (s == S_S2);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/handshake bundle between the control unit (master) and the datapath (slave).
interface control_unit_if;
  logic [15:0] busIn;
  logic        MFC;
  logic [2:0]  opControl;
  logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
  logic        PCOutEn, pcInc;
  logic        r0Latch, r1Latch, r2Latch, r3Latch;
  logic        r0Out, r1Out, r2Out, r3Out;
  logic        memEN, memRW;
  logic        MARin, MDRwriteEN, MDRreadEN, MDRout;
  logic        halted, fault;

  modport master (
    input  busIn, MFC,
    output opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn, pcInc,
           r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out,
           memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout, halted, fault
  );

  modport slave (
    output busIn, MFC,
    input  opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn, pcInc,
           r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out,
           memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout, halted, fault
  );
endinterface

// File: rtl/control_unit_reg_sel_decode.sv
// 2-bit register index plus enable to one-hot strobe; purely combinational.
module reg_sel_decode (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] onehot
);
  assign onehot = en ? (4'b0001 << idx) : 4'b0000;
endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the shared-bus datapath.
// One bus transfer per cycle; memory waits stall on MFC with a bounded timeout.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MFC_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  control_unit_if.master cu
);

  localparam int CW = $clog2(MFC_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic            run_q;
  logic [15:0]     ir_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  ctrl_t           ctl_d, ctl_q;
  logic [3:0]      lat_oh, out_oh, lat_q, out_q;
  logic [1:0]      lat_idx, out_idx;
  logic            lat_en, out_en;
  logic [3:0]      op;
  logic [1:0]      rd, rs;
  logic            ir_unused;

  assign op        = ir_q[IR_OP_HI:IR_OP_LO];
  assign rd        = ir_q[IR_RD_HI:IR_RD_LO];
  assign rs        = ir_q[IR_RS_HI:IR_RS_LO];
  assign ir_unused = ^ir_q[7:0];

  // run_q holds F0 for one cycle after reset so its strobes are actually seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_F0:  if (run_q) state_d = S_F1;
      S_F1, S_L1, S_S2: begin
        if (cu.MFC) begin
          if (state_q == S_F1)      state_d = S_F2;
          else if (state_q == S_L1) state_d = S_L2;
          else                      state_d = S_F0;
        end else if (cnt_q == CW'(MFC_TIMEOUT - 1)) begin
          state_d = S_FLT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_F2:  state_d = S_F3;
      S_F3:  state_d = S_DEC;
      S_DEC: begin
        if (op[3]) state_d = S_A0;
        else begin
          case (op)
            OP_NOP:   state_d = S_F0;
            OP_LOAD:  state_d = S_L0;
            OP_STORE: state_d = S_S0;
            OP_MOV:   state_d = S_M0;
            OP_HALT:  state_d = S_HLT;
            default:  state_d = S_F0;
          endcase
        end
      end
      S_A0:  state_d = S_A1;
      S_A1:  state_d = S_A2;
      S_A2:  state_d = S_A3;
      S_A3:  state_d = S_F0;
      S_M0:  state_d = S_F0;
      S_L0:  state_d = S_L1;
      S_L2:  state_d = S_L3;
      S_L3:  state_d = S_F0;
      S_S0:  state_d = S_S1;
      S_S1:  state_d = S_S2;
      default: state_d = state_q;
    endcase
    if (is_wait(state_d) && (state_d != state_q)) cnt_d = '0;
  end

  // Strobes are decoded from the next state and registered, so they are glitch-free.
  always_comb begin
    ctl_d   = '0;
    lat_en  = 1'b0;
    lat_idx = rd;
    out_en  = 1'b0;
    out_idx = rd;
    case (state_d)
      S_F0:        begin ctl_d.pc_out_en = 1'b1; ctl_d.mar_in = 1'b1; end
      S_F1, S_L1:  begin ctl_d.mem_en = 1'b1; ctl_d.mem_rw = MEM_READ; end
      S_F2, S_L2:  ctl_d.mdr_rd = 1'b1;
      S_F3:        begin ctl_d.mdr_out = 1'b1; ctl_d.pc_inc = 1'b1; end
      S_A0: begin
        ctl_d.alu_op = op[2:0]; ctl_d.alu_in0 = 1'b1;
        out_en = 1'b1; out_idx = rd;
      end
      S_A1: begin
        ctl_d.alu_op = op[2:0]; ctl_d.alu_in1 = 1'b1;
        out_en = 1'b1; out_idx = rs;
      end
      S_A2:  begin ctl_d.alu_op = op[2:0]; ctl_d.alu_latch = 1'b1; end
      S_A3: begin
        ctl_d.alu_op = op[2:0]; ctl_d.alu_out_en = 1'b1;
        lat_en = 1'b1; lat_idx = rd;
      end
      S_M0:  begin out_en = 1'b1; out_idx = rs; lat_en = 1'b1; lat_idx = rd; end
      S_L0:  begin out_en = 1'b1; out_idx = rs; ctl_d.mar_in = 1'b1; end
      S_L3:  begin ctl_d.mdr_out = 1'b1; lat_en = 1'b1; lat_idx = rd; end
      S_S0:  begin out_en = 1'b1; out_idx = rd; ctl_d.mar_in = 1'b1; end
      S_S1:  begin out_en = 1'b1; out_idx = rs; ctl_d.mdr_wr = 1'b1; end
      S_S2:  begin ctl_d.mem_en = 1'b1; ctl_d.mem_rw = MEM_WRITE; end
      S_HLT: ctl_d.halted = 1'b1;
      S_FLT: begin ctl_d.halted = 1'b1; ctl_d.fault = 1'b1; end
      default: ;
    endcase
  end

  reg_sel_decode u_lat_sel (.idx(lat_idx), .en(lat_en), .onehot(lat_oh));
  reg_sel_decode u_out_sel (.idx(out_idx), .en(out_en), .onehot(out_oh));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_F0;
      run_q   <= 1'b0;
      ir_q    <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      lat_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      lat_q   <= lat_oh;
      out_q   <= out_oh;
      if (state_q == S_F3) ir_q <= cu.busIn;
    end
  end

  assign cu.opControl   = ctl_q.alu_op;
  assign cu.ALUin0      = ctl_q.alu_in0;
  assign cu.ALUin1      = ctl_q.alu_in1;
  assign cu.ALUOutLatch = ctl_q.alu_latch;
  assign cu.ALUOutEn    = ctl_q.alu_out_en;
  assign cu.PCOutEn     = ctl_q.pc_out_en;
  assign cu.pcInc       = ctl_q.pc_inc;
  assign cu.memEN       = ctl_q.mem_en;
  assign cu.memRW       = ctl_q.mem_rw;
  assign cu.MARin       = ctl_q.mar_in;
  assign cu.MDRwriteEN  = ctl_q.mdr_wr;
  assign cu.MDRreadEN   = ctl_q.mdr_rd;
  assign cu.MDRout      = ctl_q.mdr_out;
  assign cu.halted      = ctl_q.halted;
  assign cu.fault       = ctl_q.fault;
  assign {cu.r3Latch, cu.r2Latch, cu.r1Latch, cu.r0Latch} = lat_q;
  assign {cu.r3Out, cu.r2Out, cu.r1Out, cu.r0Out}         = out_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-state control words, cycle counts,
// timeout, reset abandonment, and a random stream with bus-contention checks.
module tb_control_unit;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   start;

  control_unit_if bus ();

  control_unit #(.MFC_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [24:0] FAULT    = 25'(1) << 0;
  localparam logic [24:0] HALTED   = 25'(1) << 1;
  localparam logic [24:0] MDROUT   = 25'(1) << 2;
  localparam logic [24:0] MDRRD    = 25'(1) << 3;
  localparam logic [24:0] MDRWR    = 25'(1) << 4;
  localparam logic [24:0] MARIN    = 25'(1) << 5;
  localparam logic [24:0] MEMRW    = 25'(1) << 6;
  localparam logic [24:0] MEMEN    = 25'(1) << 7;
  localparam logic [24:0] PCINC    = 25'(1) << 16;
  localparam logic [24:0] PCOUT    = 25'(1) << 17;
  localparam logic [24:0] ALUOUTEN = 25'(1) << 18;
  localparam logic [24:0] ALULATCH = 25'(1) << 19;
  localparam logic [24:0] ALUIN1   = 25'(1) << 20;
  localparam logic [24:0] ALUIN0   = 25'(1) << 21;

  localparam logic [24:0] F0X = PCOUT | MARIN;
  localparam logic [24:0] RDX = MEMEN | MEMRW;
  localparam logic [24:0] F3X = MDROUT | PCINC;

  function automatic logic [24:0] ro(input int i);
    return 25'(1) << (8 + i);
  endfunction
  function automatic logic [24:0] rl(input int i);
    return 25'(1) << (12 + i);
  endfunction
  function automatic logic [24:0] opc(input int v);
    return 25'(v) << 22;
  endfunction

  logic [24:0] obs;
  assign obs = {bus.opControl, bus.ALUin0, bus.ALUin1, bus.ALUOutLatch, bus.ALUOutEn,
                bus.PCOutEn, bus.pcInc,
                bus.r3Latch, bus.r2Latch, bus.r1Latch, bus.r0Latch,
                bus.r3Out, bus.r2Out, bus.r1Out, bus.r0Out,
                bus.memEN, bus.memRW, bus.MARin, bus.MDRwriteEN, bus.MDRreadEN,
                bus.MDRout, bus.halted, bus.fault};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_strobes", 25'd0);
    rst = 1'b0;
    tick();
    chk("f0_after_reset", F0X);
  endtask

  // Entered in the F0 cycle; leaves the bench sitting in the DEC cycle.
  task automatic fetch(input logic [15:0] instr, input int delay, input string tag);
    tick();
    for (int k = 0; k <= delay; k++) begin
      chk({tag, "_f1"}, RDX);
      bus.MFC = (k == delay);
      tick();
    end
    bus.MFC = 1'b0;
    chk({tag, "_f2"}, MDRRD);
    bus.busIn = instr;
    tick();
    chk({tag, "_f3"}, F3X);
    tick();
    chk({tag, "_dec"}, 25'd0);
    bus.busIn = 16'h0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.MFC   = 1'b0;
    bus.busIn = 16'h0;
    do_reset();

    // MOV r0 <- r1
    start = cyc;
    fetch(16'h3100, 0, "mov");
    tick(); chk("mov_m0", ro(1) | rl(0));
    tick(); chk("mov_f0", F0X);
    chk_n("mov_cycles", cyc - start, 6);

    // ALU op 001, rd=r1, rs=r2
    start = cyc;
    fetch(16'h9600, 0, "alu");
    tick(); chk("alu_a0", opc(1) | ro(1) | ALUIN0);
    tick(); chk("alu_a1", opc(1) | ro(2) | ALUIN1);
    tick(); chk("alu_a2", opc(1) | ALULATCH);
    tick(); chk("alu_a3", opc(1) | ALUOUTEN | rl(1));
    tick(); chk("alu_f0", F0X);
    chk_n("alu_cycles", cyc - start, 9);

    // LOAD r3 <- mem[r2], MFC late by 3 cycles in both waits
    start = cyc;
    fetch(16'h1E00, 3, "load");
    tick(); chk("load_l0", ro(2) | MARIN);
    tick();
    for (int k = 0; k <= 3; k++) begin
      chk("load_l1", RDX);
      bus.MFC = (k == 3);
      tick();
    end
    bus.MFC = 1'b0;
    chk("load_l2", MDRRD);
    tick(); chk("load_l3", MDROUT | rl(3));
    tick(); chk("load_f0", F0X);
    chk_n("load_cycles", cyc - start, 15);

    // STORE mem[r1] <- r0
    start = cyc;
    fetch(16'h2400, 0, "store");
    tick(); chk("store_s0", ro(1) | MARIN);
    tick(); chk("store_s1", ro(0) | MDRWR);
    tick(); chk("store_s2", MEMEN);
    bus.MFC = 1'b1;
    tick(); chk("store_f0", F0X);
    bus.MFC = 1'b0;
    chk_n("store_cycles", cyc - start, 8);

    // NOP and an unassigned opcode both return straight to F0
    start = cyc;
    fetch(16'h0000, 0, "nop");
    tick(); chk("nop_f0", F0X);
    chk_n("nop_cycles", cyc - start, 5);
    start = cyc;
    fetch(16'h5A00, 0, "op5");
    tick(); chk("op5_f0", F0X);
    chk_n("op5_cycles", cyc - start, 5);

    // HALT is sticky and ignores MFC
    fetch(16'h4000, 0, "halt");
    tick(); chk("halt_hlt", HALTED);
    bus.MFC = 1'b1;
    tick(); tick(); chk("halt_stays", HALTED);
    bus.MFC = 1'b0;
    do_reset();

    // MFC never arrives during fetch
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("timeout_wait", RDX);
      tick();
    end
    chk("timeout_flt", FAULT | HALTED);
    bus.MFC = 1'b1;
    tick(); tick(); chk("timeout_stays", FAULT | HALTED);
    bus.MFC = 1'b0;
    do_reset();

    // Reset mid-LOAD abandons the access
    fetch(16'h1E00, 0, "rstload");
    tick(); chk("rstload_l0", ro(2) | MARIN);
    tick(); chk("rstload_l1", RDX);
    rst = 1'b1;
    tick(); chk("rstload_abandon", 25'd0);
    rst = 1'b0;
    tick(); chk("rstload_f0", F0X);

    // Random stream: bus drivers and register latches never collide
    for (int n = 0; n < 300; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'b0100) w[15:12] = 4'b0011;
      bus.busIn = w;
      bus.MFC   = 1'($urandom_range(0, 1));
      tick();
      chk_n("rand_bus_onehot",
            int'($onehot0({bus.ALUOutEn, bus.PCOutEn, bus.r0Out, bus.r1Out,
                           bus.r2Out, bus.r3Out, bus.MDRout})), 1);
      chk_n("rand_latch_onehot",
            int'($onehot0({bus.r0Latch, bus.r1Latch, bus.r2Latch, bus.r3Latch})), 1);
    end
    bus.MFC = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
